// File: rtl/hub75_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hub75_pkg                                                    |
// | Description : Shared types, defaults and helpers for the HUB75 capture     |
// |               receiver (pixel type, drain FSM states, fb address width).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hub75_pkg;

  localparam int HUB_ROW_BITS = 5;
  localparam int HUB_WIDTH    = 64;

  // One pixel as carried on the link: {B,G,R}
  typedef logic [2:0] rgb_t;

  // Drain walks the upper half row, then the lower half row
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TOP  = 2'd1,
    ST_BOT  = 2'd2
  } drain_state_t;

  // Framebuffer address is {half, row, x}
  function automatic int fb_addr_width(input int row_bits, input int width);
    return row_bits + 1 + $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hub75_line_buf                                               |
// | Description : Ping-pong line buffer, two banks of WIDTH x {rgb1,rgb0}.     |
// |               Write port fills one bank, registered read port drains the   |
// |               other and selects the requested half.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hub75_line_buf
  import hub75_pkg::*;
#(
  parameter  int WIDTH = HUB_WIDTH,
  localparam int XW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_wbank,
  input  logic [XW-1:0] i_waddr,
  input  logic [5:0]    i_wdata,
  input  logic          i_re,
  input  logic          i_rbank,
  input  logic [XW-1:0] i_raddr,
  input  logic          i_rhalf,
  output rgb_t          o_rdata
);

  // Line storage is deliberately not reset
  logic [5:0] r_mem [2][WIDTH];
  rgb_t       r_rdata;
  logic       w_fwd;
  logic [5:0] w_word;

  // A pixel shifted in the very cycle its bank is committed is read back
  // through this bypass so the drain never sees the stale word.
  assign w_fwd  = i_we && (i_wbank == i_rbank) && (i_waddr == i_raddr);
  assign w_word = w_fwd ? i_wdata : r_mem[i_rbank][i_raddr];

  // Fill-side write
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wbank][i_waddr] <= i_wdata;
  end

  // Registered read; this register is the framebuffer data output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= i_rhalf ? w_word[5:3] : w_word[2:0];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hub75_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hub75_capture                                                |
// | Description : HUB75 receiver. Oversamples SCLK/LATCH/addr/RGB, collects a  |
// |               row into a ping-pong line buffer and drains each committed   |
// |               row as single-pixel framebuffer writes (upper then lower).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH       = HUB_WIDTH,
  parameter int ROW_BITS    = HUB_ROW_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     hub_sclk,
  input  logic                                     hub_latch,
  input  logic [ROW_BITS-1:0]                      hub_addr,
  input  logic [2:0]                               hub_rgb0,
  input  logic [2:0]                               hub_rgb1,
  output logic                                     fb_we,
  output logic [fb_addr_width(ROW_BITS, WIDTH)-1:0] fb_addr,
  output logic [2:0]                               fb_data,
  input  logic                                     fb_ready,
  output logic                                     frame_sync,
  output logic                                     busy,
  output logic                                     err_drop,
  output logic                                     err_long,
  output logic                                     err_short,
  input  logic                                     err_clr
);

  localparam int             XW       = $clog2(WIDTH);
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam int             SW       = ROW_BITS + 8;
  localparam logic [CW-1:0]  C_WIDTH  = CW'(WIDTH);
  localparam logic [XW-1:0]  C_LAST_X = XW'(WIDTH - 1);

  // ---------------- input synchronizer and edge history ----------------
  logic [SW-1:0]       r_sync [SYNC_STAGES];
  logic [SW-1:0]       w_s;
  logic                w_sclk, w_latch;
  logic [ROW_BITS-1:0] w_addr;
  rgb_t                w_rgb0, w_rgb1;
  logic                r_sclk_d, r_latch_d;

  // All link inputs travel together so data/addr line up with the sclk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {hub_rgb1, hub_rgb0, hub_addr, hub_latch, hub_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_sclk  = w_s[0];
  assign w_latch = w_s[1];
  assign w_addr  = w_s[2 +: ROW_BITS];
  assign w_rgb0  = w_s[ROW_BITS+2 +: 3];
  assign w_rgb1  = w_s[ROW_BITS+5 +: 3];

  // History flops for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d  <= 1'b0;
      r_latch_d <= 1'b0;
    end else begin
      r_sclk_d  <= w_sclk;
      r_latch_d <= w_latch;
    end
  end

  // ---------------- shift side and commit decision ----------------
  logic                r_fill_bank, r_drain_bank, r_long_pending;
  logic [CW-1:0]       r_pix_cnt, w_cnt_eff;
  logic                w_sclk_rise, w_latch_rise, w_px_ok, w_px_over;
  logic                w_long_eff, w_line_has, w_commit, w_drop;
  logic [ROW_BITS-1:0] r_row;
  logic                r_frame_sync, r_err_drop, r_err_long, r_err_short;
  drain_state_t        r_state, w_state_nxt;

  assign w_sclk_rise  = w_sclk & ~r_sclk_d;
  assign w_latch_rise = w_latch & ~r_latch_d;
  assign w_px_ok      = w_sclk_rise && (r_pix_cnt < C_WIDTH);
  assign w_px_over    = w_sclk_rise && (r_pix_cnt == C_WIDTH);
  // A pixel arriving with the latch is counted before the commit decision
  assign w_cnt_eff    = r_pix_cnt + {{(CW-1){1'b0}}, w_px_ok};
  assign w_long_eff   = r_long_pending | w_px_over;
  assign w_line_has   = (w_cnt_eff != '0) | w_long_eff;
  assign w_commit     = w_latch_rise & w_line_has & (r_state == ST_IDLE);
  assign w_drop       = w_latch_rise & w_line_has & (r_state != ST_IDLE);

  // Pixel counter, overrun tracking, bank swap and row capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt      <= '0;
      r_long_pending <= 1'b0;
      r_fill_bank    <= 1'b0;
      r_drain_bank   <= 1'b0;
      r_row          <= '0;
      r_frame_sync   <= 1'b0;
    end else begin
      r_frame_sync <= w_commit && (w_addr == '0);
      if (w_commit || w_drop) begin
        r_pix_cnt      <= '0;
        r_long_pending <= 1'b0;
      end else begin
        if (w_px_ok)   r_pix_cnt      <= r_pix_cnt + 1'b1;
        if (w_px_over) r_long_pending <= 1'b1;
      end
      if (w_commit) begin
        r_fill_bank  <= ~r_fill_bank;
        r_drain_bank <= r_fill_bank;
        r_row        <= w_addr;
      end
    end
  end

  // Sticky error flags; a set event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_drop  <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_err_drop  <= w_drop | (r_err_drop & ~err_clr);
      r_err_long  <= (w_commit & w_long_eff) | (r_err_long & ~err_clr);
      r_err_short <= (w_commit & (w_cnt_eff < C_WIDTH)) | (r_err_short & ~err_clr);
    end
  end

  // ---------------- drain FSM ----------------
  logic          r_fb_we, r_half, w_we_nxt, w_half_nxt, w_rd_en, w_rd_bank, w_accept;
  logic [XW-1:0] r_x, w_x_nxt;
  rgb_t          w_rd_data;

  assign w_accept = r_fb_we & fb_ready;

  // Next state and next presented pixel; a read is issued whenever a new
  // pixel must appear on the outputs the following cycle
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_fb_we;
    w_x_nxt     = r_x;
    w_half_nxt  = r_half;
    w_rd_en     = 1'b0;
    w_rd_bank   = r_drain_bank;
    case (r_state)
      ST_IDLE: begin
        if (w_commit) begin
          w_state_nxt = ST_TOP;
          w_we_nxt    = 1'b1;
          w_x_nxt     = '0;
          w_half_nxt  = 1'b0;
          w_rd_en     = 1'b1;
          w_rd_bank   = r_fill_bank;
        end
      end
      ST_TOP: begin
        if (w_accept) begin
          w_rd_en = 1'b1;
          if (r_x == C_LAST_X) begin
            w_state_nxt = ST_BOT;
            w_x_nxt     = '0;
            w_half_nxt  = 1'b1;
          end else begin
            w_x_nxt = r_x + 1'b1;
          end
        end
      end
      ST_BOT: begin
        if (w_accept) begin
          if (r_x == C_LAST_X) begin
            w_state_nxt = ST_IDLE;
            w_we_nxt    = 1'b0;
          end else begin
            w_rd_en = 1'b1;
            w_x_nxt = r_x + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  // State and registered write-request/address fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fb_we <= 1'b0;
      r_x     <= '0;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fb_we <= w_we_nxt;
      r_x     <= w_x_nxt;
      r_half  <= w_half_nxt;
    end
  end

  hub75_line_buf #(.WIDTH(WIDTH)) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_px_ok),
    .i_wbank (r_fill_bank),
    .i_waddr (r_pix_cnt[XW-1:0]),
    .i_wdata ({w_rgb1, w_rgb0}),
    .i_re    (w_rd_en),
    .i_rbank (w_rd_bank),
    .i_raddr (w_x_nxt),
    .i_rhalf (w_half_nxt),
    .o_rdata (w_rd_data)
  );

  assign fb_we      = r_fb_we;
  assign fb_addr    = {r_half, r_row, r_x};
  assign fb_data    = w_rd_data;
  assign frame_sync = r_frame_sync;
  assign busy       = (r_state != ST_IDLE);
  assign err_drop   = r_err_drop;
  assign err_long   = r_err_long;
  assign err_short  = r_err_short;

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hub75_capture                                             |
// | Description : Randomized scoreboard bench for hub75_capture with a         |
// |               line-level reference model of banks, commits and errors.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hub75_capture;

  localparam int W  = 64;
  localparam int RB = 5;
  localparam int AW = RB + 1 + 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hub_sclk = 1'b0, hub_latch = 1'b0;
  logic [RB-1:0] hub_addr = '0;
  logic [2:0]    hub_rgb0 = '0, hub_rgb1 = '0;
  logic          fb_we, fb_ready = 1'b1, frame_sync, busy;
  logic [AW-1:0] fb_addr;
  logic [2:0]    fb_data;
  logic          err_drop, err_long, err_short, err_clr = 1'b0;

  always #5 clk = ~clk;

  hub75_capture #(.WIDTH(W), .ROW_BITS(RB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hub_sclk(hub_sclk), .hub_latch(hub_latch),
    .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .frame_sync(frame_sync), .busy(busy), .err_drop(err_drop),
    .err_long(err_long), .err_short(err_short), .err_clr(err_clr)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0, errors = 0;

  // Reference model: two banks of pixels, the fill bank, pixels seen this line
  logic [5:0] m_bank [2][W];
  int         m_fill = 0, m_n = 0, m_fs = 0;
  bit         m_drop = 0, m_long = 0, m_short = 0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic check_flags(input string nm);
    check({nm, "_flags"}, {29'd0, err_drop, err_long, err_short},
          {29'd0, m_drop, m_long, m_short});
  endtask

  function automatic void model_pixel(input logic [2:0] a, input logic [2:0] b);
    if (m_n < W) m_bank[m_fill][m_n] = {b, a};
    m_n++;
  endfunction

  // A latch commits a whole row (2*W writes) if nothing is outstanding,
  // otherwise the line is lost; an empty line is ignored.
  function automatic void model_latch(input logic [RB-1:0] a);
    wr_t        e;
    logic [5:0] p;
    logic [5:0] xs;
    if (m_n == 0) return;
    if (exp_q.size() > 0) begin
      m_drop = 1;
    end else begin
      for (int h = 0; h < 2; h++) begin
        for (int x = 0; x < W; x++) begin
          p      = m_bank[m_fill][x];
          xs     = x[5:0];
          e.addr = {h[0], a, xs};
          e.data = (h == 1) ? p[5:3] : p[2:0];
          exp_q.push_back(e);
        end
      end
      if (m_n < W) m_short = 1;
      if (m_n > W) m_long = 1;
      if (a == '0) m_fs++;
      m_fill ^= 1;
    end
    m_n = 0;
  endfunction

  // fb_ready pattern: 0 = always, 1 = one cycle in three, 2 = random
  int rdy_mode = 0, rdy_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin fb_ready = (rdy_cnt % 3 == 0); rdy_cnt++; end
        2:       fb_ready = 1'($urandom_range(0, 1));
        default: fb_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops and compares each accepted write, checks holds and pulses
  bit            prev_hold = 0, fs_prev = 0, fs_wide = 0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_data;
  int            acc_cnt = 0, busy_cyc = 0, fs_pulses = 0;
  wr_t           mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
      fs_prev   = 0;
    end else begin
      if (busy) busy_cyc++;
      if (frame_sync && !fs_prev) fs_pulses++;
      if (frame_sync && fs_prev) fs_wide = 1;
      fs_prev = frame_sync;
      if (prev_hold) begin
        checks++;
        if (!fb_we || fb_addr != prev_addr || fb_data != prev_data) begin
          errors++;
          $display("FAIL hold we=%0b addr=%0h data=%0h expected we=1 addr=%0h data=%0h",
                   fb_we, fb_addr, fb_data, prev_addr, prev_data);
        end
      end
      if (fb_we && fb_ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h expected none", fb_addr, fb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.addr != fb_addr || mon_e.data != fb_data) begin
            errors++;
            $display("FAIL write addr=%0h data=%0h expected addr=%0h data=%0h",
                     fb_addr, fb_data, mon_e.addr, mon_e.data);
          end
        end
      end
      prev_hold = fb_we && !fb_ready;
      prev_addr = fb_addr;
      prev_data = fb_data;
    end
  end

  task automatic shift_px(input logic [2:0] a, input logic [2:0] b, input bit with_latch);
    hub_rgb0 = a; hub_rgb1 = b; hub_sclk = 0; hub_latch = 0;
    repeat (2) @(negedge clk);
    hub_sclk  = 1;
    hub_latch = with_latch;
    model_pixel(a, b);
    if (with_latch) model_latch(hub_addr);
    repeat (2) @(negedge clk);
    hub_sclk = 0; hub_latch = 0;
  endtask

  task automatic do_latch();
    hub_latch = 1;
    model_latch(hub_addr);
    repeat (2) @(negedge clk);
    hub_latch = 0;
    repeat (2) @(negedge clk);
  endtask

  // pattern=1: rgb0 = x[2:0], rgb1 = ~x[2:0]; otherwise random colours
  task automatic send_line(input logic [RB-1:0] a, input int n, input bit pattern);
    logic [2:0] v;
    hub_addr = a;
    for (int i = 0; i < n; i++) begin
      if (pattern) begin
        v = i[2:0];
        shift_px(v, ~v, 0);
      end else begin
        shift_px(3'($urandom), 3'($urandom), 0);
      end
    end
    do_latch();
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({nm, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    m_drop = 0; m_long = 0; m_short = 0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, t;
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < W; x++) m_bank[b][x] = '0;

    repeat (4) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_fb_we", int'(fb_we), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_sync", int'(frame_sync), 0);
    check_flags("reset");

    // Counting ramp on row 5, full-rate drain
    busy_cyc = 0;
    send_line(5'd5, W, 1);
    wait_idle("t1");
    check("t1_busy_cycles", busy_cyc, 2 * W);
    check_flags("t1");

    // Row 0 commit, then empty PWM re-latches
    send_line(5'd0, W, 0);
    wait_idle("t2");
    check("t2_frame_sync_pulses", fs_pulses, m_fs);
    check("t2_frame_sync_width", int'(fs_wide), 0);
    a0 = acc_cnt;
    repeat (3) do_latch();
    repeat (16) @(negedge clk);
    check("t2_no_writes", acc_cnt, a0);
    check_flags("t2");

    // Overlong line, then short line, then clear
    send_line(5'd9, 70, 0);
    wait_idle("t3a");
    check_flags("t3_long");
    send_line(5'd17, 60, 0);
    wait_idle("t3b");
    check_flags("t3_short");
    clear_err();
    check_flags("t3_clear");

    // Throttled drain with a second line latched while still busy
    rdy_mode = 1;
    send_line(5'd3, W, 0);
    send_line(5'd22, W, 0);
    wait_idle("t4");
    check_flags("t4_drop");
    clear_err();
    rdy_mode = 0;

    // Last pixel's sclk edge coincides with the latch edge
    hub_addr = 5'd12;
    for (int i = 0; i < W - 1; i++) shift_px(3'($urandom), 3'($urandom), 0);
    shift_px(3'($urandom), 3'($urandom), 1);
    repeat (4) @(negedge clk);
    wait_idle("t5");
    check_flags("t5");

    // Reset in the middle of a drain
    rdy_mode = 2;
    acc_cnt = 0;
    send_line(5'd7, W, 0);
    t = 0;
    while (acc_cnt < 40 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("t6_reached_40", int'(acc_cnt >= 40), 1);
    #2;
    rst_n = 0;
    #1;
    check("t6_reset_fb_we", int'(fb_we), 0);
    check("t6_reset_busy", int'(busy), 0);
    exp_q.delete();
    m_fill = 0; m_n = 0; m_drop = 0; m_long = 0; m_short = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_flags("t6_after_reset");
    acc_cnt = 0;
    send_line(5'd30, W, 0);
    wait_idle("t6");
    check("t6_write_count", acc_cnt, 2 * W);
    check_flags("t6");

    // Random rows and lengths under random backpressure
    for (int k = 0; k < 4; k++) begin
      send_line(5'($urandom_range(0, 31)), $urandom_range(60, 68), 0);
      wait_idle("rand");
      check_flags("rand");
      clear_err();
    end

    check("final_frame_sync_pulses", fs_pulses, m_fs);
    check("final_frame_sync_width", int'(fs_wide), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receiver end of the HUB75 LED-panel link that our scan and pattern logic drives: SCLK, LATCH, 5-bit row address, RGB0 for the upper half, RGB1 for the lower half.
- Oversamples the link in the system clock and collects each shifted row into a ping-pong line buffer.
- On LATCH, commits the row and drains it as single-pixel writes into a framebuffer port.
- Used for panel emulation, loopback verification of the driver, and capture onto a second display.

Parameters:
- WIDTH, 64: pixels per shifted row (columns).
- ROW_BITS, 5: row address width; rows per half = 2**ROW_BITS.
- SYNC_STAGES, 2: synchronizer depth on all hub_* inputs.

Ports:
- clk, in, 1: system clock; must be ≥4× the SCLK frequency.
- rst_n, in, 1: asynchronous active-low reset.
- hub_sclk, in, 1: HUB75 shift clock; data is sampled on its rising edge.
- hub_latch, in, 1: HUB75 latch; its rising edge commits the row.
- hub_addr, in, ROW_BITS: row address.
- hub_rgb0, in, 3: {B,G,R} for the upper half.
- hub_rgb1, in, 3: {B,G,R} for the lower half.
- fb_we, out, 1: framebuffer write request.
- fb_addr, out, ROW_BITS+1+clog2(WIDTH): {y, x}.
- fb_data, out, 3: {B,G,R}.
- fb_ready, in, 1: framebuffer accepts the write.
- frame_sync, out, 1: one-cycle pulse when row 0 is committed.
- busy, out, 1: drain in progress.
- err_drop, out, 1: sticky; a line was lost.
- err_long, out, 1: sticky; a line had more than WIDTH pixels.
- err_short, out, 1: sticky; a line had fewer than WIDTH pixels.
- err_clr, in, 1: synchronous clear of all sticky errors.

Behaviour:
- Input synchronization and sampling:
  - All hub_* inputs pass through SYNC_STAGES flops, then one extra history flop on sclk and latch for edge detection.
  - Data and addr are taken from the same synchronizer stage as the sclk edge.
- Shift side:
  - Counter pix_cnt is 0..WIDTH and resets to 0 on each commit.
  - On an sclk rising edge with pix_cnt < WIDTH: write {rgb1,rgb0} into the fill bank at x=pix_cnt, then increment pix_cnt.
  - On an sclk rising edge with pix_cnt == WIDTH: drop the pixel, set long_pending.
- Latch rising edge:
  - pix_cnt == 0 and no long_pending: ignore silently. Repeated latching for PWM is legal.
  - Otherwise, if the drain is idle: capture row = hub_addr, swap banks, start the drain, reset pix_cnt.
    - Set err_short if pix_cnt < WIDTH.
    - Set err_long if long_pending, then clear long_pending.
    - Unwritten columns of a short line drain stale bank contents.
  - Otherwise (drain busy): discard the fill bank contents, set err_drop, reset pix_cnt and long_pending. No commit.
- Simultaneous sclk and latch edges in the same cycle: the pixel is shifted first, then the commit includes it.
- Drain FSM:
  - States: IDLE → TOP → BOT → IDLE.
  - TOP issues x=0..WIDTH-1 with y={0,row} and data=rgb0.
  - BOT issues x=0..WIDTH-1 with y={1,row} and data=rgb1.
- Handshake:
  - fb_we, fb_addr and fb_data are registered.
  - Once fb_we is asserted, addr and data stay stable until fb_we && fb_ready.
  - The next pixel is presented the cycle after acceptance. With fb_ready held high this gives one write per cycle, 2*WIDTH cycles per line.
- Latency and status:
  - First fb_we rises 1 cycle after the synchronized latch edge is detected.
  - busy = (state != IDLE).
  - frame_sync pulses in the commit cycle when row == 0.
- Error flags:
  - Sticky until err_clr.
  - If err_clr and a set event occur in the same cycle, set wins.
- Reset (asserted at any time, including mid-drain or mid-line):
  - fb_we=0, fb_addr=0, fb_data=0, frame_sync=0, busy=0, all err_*=0.
  - FSM to IDLE, fill bank 0, pix_cnt 0, edge history 0.
  - Line buffer contents are not reset.
- Widths: x wraps are impossible by construction (pix_cnt saturates at WIDTH). y = {half, row}.

Decomposition:
- Package hub75_pkg holds:
  - rgb_t (3-bit {B,G,R}).
  - HUB_ROW_BITS and HUB_WIDTH defaults.
  - fb_addr width function.
  - Drain state enum.
- One natural sub-module: hub75_line_buf.
  - Dual-bank WIDTH×6 storage.
  - Write port on the fill bank, read port on the drain bank.
  - Registered read, absorbed into the drain pipeline.

Test Plan:
1. Reset, then shift 64 pixels of rgb0=x[2:0], rgb1=~x[2:0], addr=5, latch, fb_ready=1 → 128 writes: y=5, x=0..63 with data x[2:0]; then y=37 with ~x[2:0]; no errors; busy high for exactly 128 cycles.
2. Row 0 commit → frame_sync is a single one-cycle pulse; a repeated latch with no pixels in between → no writes, no flags.
3. 70 pixels, then latch → writes carry only the first 64 pixels, err_long=1. Next a 60-pixel line → err_short=1. err_clr → all flags 0.
4. fb_ready toggled 1-in-3 → every write is held stable until accepted, all 128 delivered in order. A second line whose latch arrives while still draining → err_drop=1 and the drain of the first line completes intact.
5. sclk edge and latch edge in the same synchronized cycle at pixel 63 → line committed with 64 pixels, no err_short.
6. rst_n asserted mid-drain at write 40 → fb_we low immediately. After release, a fresh line drains 128 writes starting at x=0.
